// File: rtl/syn_fifo_param.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// syn_fifo_param
//
// Single-clock FIFO with a configurable data width and a power-of-two depth.
// Besides the usual full/empty flags it provides programmable almost-full and
// almost-empty thresholds, an occupancy count, and one-cycle status pulses.
// These pulses report each accepted or rejected request.
//
// Parameters:
//   DATA_WIDTH  width of din/dout
//   ADDR_WIDTH  log2 of the depth (DEPTH = 2**ADDR_WIDTH)
//   PROG_FULL   almost_full when occupancy >= PROG_FULL
//   PROG_EMPTY  almost_empty when occupancy <= PROG_EMPTY
//
// Ports:
//   clk           rising-edge clock for all logic
//   srst_n        synchronous reset, active low
//   din / wr_en   write data and write request
//   rd_en         read request
//   dout          registered read data, held when no read is accepted
//   valid         dout was loaded by a read accepted on the previous edge
//   wr_ack        a write was accepted on the previous edge
//   overflow      a write was rejected (FIFO full) on the previous edge
//   underflow     a read was rejected (FIFO empty) on the previous edge
//   full, empty, almost_full, almost_empty, data_count
//                 occupancy status after the most recent edge
// ---------------------------------------------------------------------------
module syn_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int PROG_FULL  = 2**ADDR_WIDTH - 4,
  parameter int PROG_EMPTY = 4
) (
  input  logic                  clk,
  input  logic                  srst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  wr_ack,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   DEPTH_C      = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   PROG_FULL_C  = (ADDR_WIDTH+1)'(PROG_FULL);
  localparam logic [ADDR_WIDTH:0]   PROG_EMPTY_C = (ADDR_WIDTH+1)'(PROG_EMPTY);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE      = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE      = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;

  logic                  wr_accept;
  logic                  rd_accept;

  // Acceptance uses the registered flags. So when both requests arrive on a
  // full FIFO, only the read is taken. On an empty FIFO, only the write is
  // taken.
  // Status flags are derived from the next count, so they describe the FIFO
  // as it will be after this edge.
  always_comb begin
    wr_accept = wr_en && !full_q;
    rd_accept = rd_en && !empty_q;

    wptr_d = wr_accept ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d = rd_accept ? (rptr_q + PTR_ONE) : rptr_q;

    count_d = count_q;
    if (wr_accept && !rd_accept) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_accept && !wr_accept) begin
      count_d = count_q - CNT_ONE;
    end

    dout_d      = rd_accept ? mem[rptr_q] : dout_q;
    valid_d     = rd_accept;
    wr_ack_d    = wr_accept;
    overflow_d  = wr_en && !wr_accept;
    underflow_d = rd_en && !rd_accept;

    full_d         = (count_d == DEPTH_C);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= PROG_FULL_C);
    almost_empty_d = (count_d <= PROG_EMPTY_C);
  end

  // The storage array has no reset. Writes are suppressed while reset is
  // asserted, so a reset cycle never deposits data.
  always_ff @(posedge clk) begin
    if (srst_n && wr_accept) begin
      mem[wptr_q] <= din;
    end
  end

  // Control and output registers. Reset overrides any request in the same
  // cycle and discards everything that was queued.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      dout_q         <= '0;
      valid_q        <= 1'b0;
      wr_ack_q       <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= (PROG_FULL == 0);
      almost_empty_q <= 1'b1;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      dout_q         <= dout_d;
      valid_q        <= valid_d;
      wr_ack_q       <= wr_ack_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign dout         = dout_q;
  assign valid        = valid_q;
  assign wr_ack       = wr_ack_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign data_count   = count_q;

endmodule

// File: tb/tb_syn_fifo_param.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_syn_fifo_param
//
// Two FIFO instances share one 100 MHz clock:
//   unit 0: default configuration (8 x 512, thresholds 508 / 4)
//   unit 1: 16 x 16, thresholds 14 / 2
//
// The directed sequences run on unit 0. A long random stream runs on unit 1.
// Each unit has a queue-based reference model that is advanced on the rising
// edge. It is compared against every output on each falling edge.
// ---------------------------------------------------------------------------
module tb_syn_fifo_param;

  localparam int A_DEPTH = 512;
  localparam int A_PF    = 508;
  localparam int A_PE    = 4;
  localparam int B_DEPTH = 16;
  localparam int B_PF    = 14;
  localparam int B_PE    = 2;

  logic clk = 1'b0;

  // Unit 0 signals
  logic        a_srst_n, a_wr_en, a_rd_en;
  logic [7:0]  a_din, a_dout;
  logic        a_valid, a_wr_ack, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
  logic [9:0]  a_count;

  // Unit 1 signals
  logic        b_srst_n, b_wr_en, b_rd_en;
  logic [15:0] b_din, b_dout;
  logic        b_valid, b_wr_ack, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
  logic [4:0]  b_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  syn_fifo_param dut_a (
    .clk(clk), .srst_n(a_srst_n), .din(a_din), .wr_en(a_wr_en), .rd_en(a_rd_en),
    .dout(a_dout), .valid(a_valid), .wr_ack(a_wr_ack), .full(a_full), .empty(a_empty),
    .almost_full(a_afull), .almost_empty(a_aempty), .data_count(a_count),
    .overflow(a_ovf), .underflow(a_unf)
  );

  syn_fifo_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .PROG_FULL(14), .PROG_EMPTY(2)) dut_b (
    .clk(clk), .srst_n(b_srst_n), .din(b_din), .wr_en(b_wr_en), .rd_en(b_rd_en),
    .dout(b_dout), .valid(b_valid), .wr_ack(b_wr_ack), .full(b_full), .empty(b_empty),
    .almost_full(b_afull), .almost_empty(b_aempty), .data_count(b_count),
    .overflow(b_ovf), .underflow(b_unf)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs to a unit (called at a falling edge), then wait
  // until the next falling edge so the outputs of that rising edge are stable
  task automatic applyStimulus(input int unit, input logic rst_n, input logic we,
                               input logic re, input logic [15:0] d);
    if (unit == 0) begin
      a_srst_n = rst_n; a_wr_en = we; a_rd_en = re; a_din = d[7:0];
    end else begin
      b_srst_n = rst_n; b_wr_en = we; b_rd_en = re; b_din = d;
    end
    @(negedge clk);
  endtask

  // Reference model for unit 0: queue of stored words and expected pulses
  logic [7:0] ma_q[$];
  logic [7:0] ma_dout;
  bit         ma_valid, ma_ack, ma_ovf, ma_unf, ma_wa, ma_ra, armed_a = 0;
  int         ma_n;

  always @(posedge clk) begin
    if (!a_srst_n) begin
      ma_q.delete();
      ma_dout = '0; ma_valid = 0; ma_ack = 0; ma_ovf = 0; ma_unf = 0;
      armed_a = 1;
    end else begin
      ma_wa    = a_wr_en && (ma_q.size() < A_DEPTH);
      ma_ra    = a_rd_en && (ma_q.size() > 0);
      ma_valid = ma_ra;
      ma_ack   = ma_wa;
      ma_ovf   = a_wr_en && !ma_wa;
      ma_unf   = a_rd_en && !ma_ra;
      if (ma_ra) ma_dout = ma_q.pop_front();
      if (ma_wa) ma_q.push_back(a_din);
    end
  end

  always @(negedge clk) begin
    if (armed_a) begin
      ma_n = ma_q.size();
      checkOutput("a_dout",   32'(a_dout),   32'(ma_dout));
      checkOutput("a_valid",  32'(a_valid),  32'(ma_valid));
      checkOutput("a_wr_ack", 32'(a_wr_ack), 32'(ma_ack));
      checkOutput("a_ovf",    32'(a_ovf),    32'(ma_ovf));
      checkOutput("a_unf",    32'(a_unf),    32'(ma_unf));
      checkOutput("a_count",  32'(a_count),  32'(ma_n));
      checkOutput("a_full",   32'(a_full),   32'(ma_n == A_DEPTH));
      checkOutput("a_empty",  32'(a_empty),  32'(ma_n == 0));
      checkOutput("a_afull",  32'(a_afull),  32'(ma_n >= A_PF));
      checkOutput("a_aempty", 32'(a_aempty), 32'(ma_n <= A_PE));
    end
  end

  // Reference model for unit 1
  logic [15:0] mb_q[$];
  logic [15:0] mb_dout;
  bit          mb_valid, mb_ack, mb_ovf, mb_unf, mb_wa, mb_ra, armed_b = 0;
  int          mb_n;

  always @(posedge clk) begin
    if (!b_srst_n) begin
      mb_q.delete();
      mb_dout = '0; mb_valid = 0; mb_ack = 0; mb_ovf = 0; mb_unf = 0;
      armed_b = 1;
    end else begin
      mb_wa    = b_wr_en && (mb_q.size() < B_DEPTH);
      mb_ra    = b_rd_en && (mb_q.size() > 0);
      mb_valid = mb_ra;
      mb_ack   = mb_wa;
      mb_ovf   = b_wr_en && !mb_wa;
      mb_unf   = b_rd_en && !mb_ra;
      if (mb_ra) mb_dout = mb_q.pop_front();
      if (mb_wa) mb_q.push_back(b_din);
    end
  end

  always @(negedge clk) begin
    if (armed_b) begin
      mb_n = mb_q.size();
      checkOutput("b_dout",   32'(b_dout),   32'(mb_dout));
      checkOutput("b_valid",  32'(b_valid),  32'(mb_valid));
      checkOutput("b_wr_ack", 32'(b_wr_ack), 32'(mb_ack));
      checkOutput("b_ovf",    32'(b_ovf),    32'(mb_ovf));
      checkOutput("b_unf",    32'(b_unf),    32'(mb_unf));
      checkOutput("b_count",  32'(b_count),  32'(mb_n));
      checkOutput("b_full",   32'(b_full),   32'(mb_n == B_DEPTH));
      checkOutput("b_empty",  32'(b_empty),  32'(mb_n == 0));
      checkOutput("b_afull",  32'(b_afull),  32'(mb_n >= B_PF));
      checkOutput("b_aempty", 32'(b_aempty), 32'(mb_n <= B_PE));
    end
  end

  initial begin
    a_srst_n = 0; a_wr_en = 0; a_rd_en = 0; a_din = '0;
    b_srst_n = 0; b_wr_en = 0; b_rd_en = 0; b_din = '0;

    // Reset held for two edges with both requests active
    $display("[TB] reset with requests active");
    applyStimulus(0, 0, 1, 1, 16'h00AA);
    applyStimulus(0, 0, 1, 1, 16'h00AA);
    checkOutput("rst_empty",  32'(a_empty),  32'd1);
    checkOutput("rst_aempty", 32'(a_aempty), 32'd1);
    checkOutput("rst_full",   32'(a_full),   32'd0);
    checkOutput("rst_count",  32'(a_count),  32'd0);
    checkOutput("rst_dout",   32'(a_dout),   32'd0);
    checkOutput("rst_valid",  32'(a_valid),  32'd0);
    checkOutput("rst_ovf",    32'(a_ovf),    32'd0);
    checkOutput("rst_unf",    32'(a_unf),    32'd0);
    b_srst_n = 1;

    // Fill to full with 0x00..0xFF twice
    $display("[TB] fill to full");
    for (int i = 0; i < 512; i++) begin
      applyStimulus(0, 1, 1, 0, 16'(i % 256));
      if (i == 506) checkOutput("fill_afull_507", 32'(a_afull), 32'd0);
      if (i == 507) checkOutput("fill_afull_508", 32'(a_afull), 32'd1);
      if (i == 510) checkOutput("fill_full_511",  32'(a_full),  32'd0);
      if (i == 511) begin
        checkOutput("fill_full_512",  32'(a_full),  32'd1);
        checkOutput("fill_count_512", 32'(a_count), 32'd512);
        checkOutput("fill_ack_512",   32'(a_wr_ack), 32'd1);
      end
    end
    applyStimulus(0, 1, 1, 0, 16'h0055);
    checkOutput("ovf_pulse", 32'(a_ovf),    32'd1);
    checkOutput("ovf_ack",   32'(a_wr_ack), 32'd0);
    checkOutput("ovf_count", 32'(a_count),  32'd512);
    applyStimulus(0, 1, 0, 0, 16'h0000);
    checkOutput("ovf_single", 32'(a_ovf), 32'd0);

    // Drain in order
    $display("[TB] drain");
    for (int i = 0; i < 512; i++) begin
      applyStimulus(0, 1, 0, 1, 16'h0000);
      checkOutput("drain_dout",  32'(a_dout),  32'(i % 256));
      checkOutput("drain_valid", 32'(a_valid), 32'd1);
      if (i == 506) checkOutput("drain_aempty_5", 32'(a_aempty), 32'd0);
      if (i == 507) checkOutput("drain_aempty_4", 32'(a_aempty), 32'd1);
      if (i == 510) checkOutput("drain_empty_1",  32'(a_empty),  32'd0);
      if (i == 511) checkOutput("drain_empty_0",  32'(a_empty),  32'd1);
    end
    applyStimulus(0, 1, 0, 1, 16'h0000);
    checkOutput("unf_pulse", 32'(a_unf),   32'd1);
    checkOutput("unf_dout",  32'(a_dout),  32'h00FF);
    checkOutput("unf_valid", 32'(a_valid), 32'd0);

    // Simultaneous write and read at the boundaries
    $display("[TB] simultaneous at boundaries");
    applyStimulus(0, 1, 1, 1, 16'h003C);
    checkOutput("both_empty_count", 32'(a_count),  32'd1);
    checkOutput("both_empty_unf",   32'(a_unf),    32'd1);
    checkOutput("both_empty_ack",   32'(a_wr_ack), 32'd1);
    for (int i = 1; i < 512; i++) applyStimulus(0, 1, 1, 0, 16'(i % 256));
    checkOutput("refill_full", 32'(a_full), 32'd1);
    applyStimulus(0, 1, 1, 1, 16'h0099);
    checkOutput("both_full_count", 32'(a_count), 32'd511);
    checkOutput("both_full_ovf",   32'(a_ovf),   32'd1);
    checkOutput("both_full_valid", 32'(a_valid), 32'd1);
    checkOutput("both_full_dout",  32'(a_dout),  32'h003C);

    // Reset in the middle of traffic discards everything
    $display("[TB] reset mid-operation");
    applyStimulus(0, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 0, 16'(8'hA0 + i));
    for (int i = 0; i < 3; i++)  applyStimulus(0, 1, 0, 1, 16'h0000);
    checkOutput("mid_count_before", 32'(a_count), 32'd7);
    applyStimulus(0, 0, 0, 0, 16'h0000);
    checkOutput("mid_count", 32'(a_count), 32'd0);
    checkOutput("mid_empty", 32'(a_empty), 32'd1);
    applyStimulus(0, 1, 1, 0, 16'h0077);
    applyStimulus(0, 1, 0, 1, 16'h0000);
    checkOutput("mid_new_dout",  32'(a_dout),  32'h0077);
    checkOutput("mid_new_valid", 32'(a_valid), 32'd1);
    applyStimulus(0, 1, 0, 0, 16'h0000);

    // Random streaming on the small instance: 250 us at 100 MHz
    $display("[TB] random streaming on 16x16 instance");
    applyStimulus(1, 0, 0, 0, 16'h0000);
    for (int c = 0; c < 25000; c++) begin
      applyStimulus(1, 1, ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 6),
                    16'($urandom));
    end
    applyStimulus(1, 1, 0, 0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
